// File: rtl/data_memory_load_unit.sv
// Sequential load unit: one request at a time, one or two aligned memory
// beats, right-justified sign/zero-extended result one cycle after RESP.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_*               load request (valid/ready), byte address, size, sign
//   mem_req_valid/ready aligned read request handshake, mem_addr
//   mem_rvalid/rdata    read data return
//   resp_valid/data     one-cycle result pulse, data held until next pulse
//   resp_fault          qualifies resp_valid; illegal request
//
// Option: define DATA_MEMORY_LOAD_MISALIGN_TRAP_EN to fault misaligned loads
// instead of splitting them.
module data_memory_load_unit #(
  parameter  int XLEN        = 32,
  parameter  int ADDR_WIDTH  = 32,
  localparam int OFFSET_BITS = $clog2(XLEN / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_sign_extend,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_data,
  output logic                  resp_fault
);

  typedef enum logic [2:0] {
    IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP, FAULT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [1:0]             size_q;
  logic                   sext_q;
  logic                   split_q;
  logic [XLEN-1:0]        lo_q;
  logic [XLEN-1:0]        hi_q;
  logic                   resp_valid_q;
  logic                   resp_fault_q;
  logic [XLEN-1:0]        resp_data_q;

  logic [OFFSET_BITS-1:0] req_off;
  logic                   width_illegal;
  logic                   req_illegal;
  logic                   req_split;

  assign req_off       = req_addr[OFFSET_BITS-1:0];
  assign width_illegal = (XLEN == 32) && (req_size == 2'b11);

`ifdef DATA_MEMORY_LOAD_MISALIGN_TRAP_EN
  logic [4:0] lane_mask;
  always_comb begin
    lane_mask   = (5'd1 << req_size) - 5'd1;
    req_illegal = width_illegal
                | ((5'(req_off) & lane_mask) != 5'd0);
  end
  // Aligned accesses never cross a word, so the split path is dead.
  assign req_split = 1'b0;
`else
  logic [4:0] span;
  assign span        = 5'(req_off) + (5'd1 << req_size);
  assign req_split   = span > 5'(XLEN / 8);
  assign req_illegal = width_illegal;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (req_valid)
          state_nx = req_illegal ? FAULT : REQ1;
      REQ1:
        if (mem_req_ready) state_nx = WAIT1;
      WAIT1:
        if (mem_rvalid)
          state_nx = split_q ? REQ2 : RESP;
      REQ2:
        if (mem_req_ready) state_nx = WAIT2;
      WAIT2:
        if (mem_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      FAULT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [ADDR_WIDTH-1:0] base_addr;
  assign base_addr = {addr_q[ADDR_WIDTH-1:OFFSET_BITS],
                      {OFFSET_BITS{1'b0}}};

  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    unique case (1'b1)
      state == IDLE: req_ready = 1'b1;
      state == REQ1: begin
        mem_req_valid = 1'b1;
        mem_addr      = base_addr;
      end
      state == REQ2: begin
        mem_req_valid = 1'b1;
        mem_addr      = base_addr + ADDR_WIDTH'(XLEN / 8);
      end
      default: ;
    endcase
  end

  // Extraction: shift the beat pair down, then move the kept field to the
  // top and back so one shifter handles both extension modes.
  logic [OFFSET_BITS-1:0] off_q;
  logic [XLEN-1:0]        win;
  logic [XLEN-1:0]        left;
  logic signed [XLEN-1:0] sleft;
  logic [XLEN-1:0]        sra;
  logic [XLEN-1:0]        ext;
  logic [6:0]             sh;

  assign off_q = addr_q[OFFSET_BITS-1:0];

  always_comb begin
    win = XLEN'({hi_q, lo_q} >> {off_q, 3'b000});
    unique case (size_q)
      2'b00:   sh = 7'(XLEN - 8);
      2'b01:   sh = 7'(XLEN - 16);
      2'b10:   sh = 7'(XLEN - 32);
      default: sh = 7'd0;
    endcase
    left  = win << sh;
    sleft = left;
    sra   = sleft >>> sh;
    ext   = sext_q ? sra : (left >> sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      size_q       <= '0;
      sext_q       <= 1'b0;
      split_q      <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        sext_q  <= req_sign_extend;
        split_q <= req_split;
        hi_q    <= '0;
      end
      if (state == WAIT1 && mem_rvalid) lo_q <= mem_rdata;
      if (state == WAIT2 && mem_rvalid) hi_q <= mem_rdata;
      resp_valid_q <= (state == RESP) || (state == FAULT);
      resp_fault_q <= (state == FAULT);
      if (state == RESP)  resp_data_q <= ext;
      if (state == FAULT) resp_data_q <= '0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_data  = resp_data_q;

endmodule
